painel_scan_scheduler: RTL and testbench
========================================

Name: painel_scan_scheduler

Overview:
- Synchronous replacement for the ripple T-flip-flop clock chain in the digital panel.
- Uses single-cycle enables on the one system clock instead of derived clocks.
- Sequences the column scan of the multiplexed display, with anti-ghosting blanking.
- Schedules message scroll steps so the offset only changes at a frame boundary, giving tear-free scrolling.

Parameters:
SCAN_DIV, 65536, clk cycles per column slot (>= 2).
BLANK_CYC, 64, blanked cycles at the start of each column slot (< SCAN_DIV).
NUM_COLS, 5, number of multiplexed columns (>= 2).
SCROLL_DIV, 256, scan ticks per scroll request (>= 1).
MSG_LEN, 16, message length; offset wraps modulo MSG_LEN (>= 2).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  run scan; 0 = idle, columns off
hold  in  1  freeze scrolling; scanning continues
dir  in  1  scroll direction: 0 = +1, 1 = -1
load  in  1  load offset_in into msg_offset
offset_in  in  clog2(MSG_LEN)  offset to load
col_n  out  NUM_COLS  active-low one-hot column drive
col_idx  out  clog2(NUM_COLS)  current column index
msg_offset  out  clog2(MSG_LEN)  current message start offset
scan_tick  out  1  1-cycle pulse, last cycle of each column slot
frame_done  out  1  1-cycle pulse, last cycle of the last column
scroll_tick  out  1  1-cycle pulse, cycle after msg_offset changes

Behaviour:
- Reset state:
  - run=0, presc=0, col_idx=0, scan_cnt=0, pending=0, msg_offset=0.
  - col_n = all ones; scan_tick, frame_done and scroll_tick = 0.
- Run flag:
  - run <= en every edge.
  - The FSM state is decoded: IDLE (run=0), BLANK (run=1 and presc<BLANK_CYC), DRIVE (run=1 and presc>=BLANK_CYC).
- IDLE:
  - presc, col_idx, scan_cnt and pending are forced to 0 each edge.
  - msg_offset is retained.
  - col_n is all ones; no pulses.
- Prescaler:
  - While run=1, presc counts 0..SCAN_DIV-1 and wraps.
- col_n:
  - DRIVE: col_n = ~(1<<col_idx).
  - BLANK and IDLE: col_n = all ones.
- scan_tick = run and presc==SCAN_DIV-1, decoded from registers (no extra latency).
- On a scan_tick edge:
  - presc <= 0.
  - col_idx <= col_idx+1, wrapping NUM_COLS-1 -> 0.
  - scan_cnt <= scan_cnt+1, wrapping SCROLL_DIV-1 -> 0.
- frame_done = scan_tick and col_idx==NUM_COLS-1.
- Scroll request: a scan_tick with scan_cnt==SCROLL_DIV-1 and hold=0 sets pending.
- Scroll apply: on a frame_done edge where pending=1, or where the request is raised in that same cycle:
  - msg_offset steps by ±1 modulo MSG_LEN (dir=0: MSG_LEN-1 -> 0; dir=1: 0 -> MSG_LEN-1).
  - pending <= 0.
  - scroll_tick = 1 in the following cycle.
- hold=1:
  - Clears pending and blocks new requests.
  - scan_cnt keeps counting.
- load=1, highest priority after rst, takes effect in any state:
  - msg_offset <= offset_in, or 0 if offset_in >= MSG_LEN.
  - pending <= 0.
  - A scroll apply in the same cycle is discarded and no scroll_tick is generated.
- en deasserted mid-slot: the next edge enters IDLE and columns go off immediately after that edge. Re-enable restarts at column 0, blank phase.
- rst mid-operation wins over everything and returns to the reset state on the next edge.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2, NUM_COLS=4, SCROLL_DIV=3, MSG_LEN=6.
1. Scan sequence: rst, then en=1 held -> after the first edge, col_n=1111 for 2 cycles then 1110 for 6 cycles, scan_tick at presc=7, then 1111 ×2 and 1101 ×6. col_idx cycles 0,1,2,3,0. frame_done every 32 cycles.
2. Deferred scroll: en=1, hold=0, dir=0 -> pending set at scan tick 3; offset 0→1 at tick 4 (frame_done) and scroll_tick the cycle after. Offset 1→2 at tick 8 and 2→3 at tick 12. Offset is never changed at a non-frame_done edge.
3. Wrap-around: load offset_in=5, dir=0 -> next apply gives 0. load 0, dir=1 -> next apply gives 5.
4. Hold: hold=1 across ticks 1-8 -> msg_offset constant and no scroll_tick. Release at tick 8 -> the next request at tick 9 applies at tick 12.
5. Mid-operation stop: deassert en in DRIVE of column 2 -> col_n=1111 from the next edge, col_idx=0, offset retained. Re-enable -> 2 blank cycles then 1110.
6. Load conflict: load=1 with offset_in=7 on a frame_done edge with pending=1 -> msg_offset=0, pending cleared, no scroll_tick. rst asserted mid-frame -> reset values on the next edge.

Source files
------------

// File: rtl/painel_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : painel_scan_scheduler
// Description : Single-clock column scan sequencer with anti-ghost blanking
//               and frame-aligned message scroll scheduling.
// Revision    : 1.0 - initial release
// ============================================================================
module painel_scan_scheduler #(
    parameter int SCAN_DIV   = 65536,
    parameter int BLANK_CYC  = 64,
    parameter int NUM_COLS   = 5,
    parameter int SCROLL_DIV = 256,
    parameter int MSG_LEN    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        hold,
    input  logic                        dir,
    input  logic                        load,
    input  logic [$clog2(MSG_LEN)-1:0]  offset_in,
    output logic [NUM_COLS-1:0]         col_n,
    output logic [$clog2(NUM_COLS)-1:0] col_idx,
    output logic [$clog2(MSG_LEN)-1:0]  msg_offset,
    output logic                        scan_tick,
    output logic                        frame_done,
    output logic                        scroll_tick
);

    localparam int c_PRESC_W = $clog2(SCAN_DIV);
    localparam int c_IDX_W   = $clog2(NUM_COLS);
    localparam int c_OFF_W   = $clog2(MSG_LEN);
    localparam int c_CNT_W   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(SCAN_DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_BLANK_END  = c_PRESC_W'(BLANK_CYC);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(NUM_COLS - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_ONE    = c_IDX_W'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST   = c_CNT_W'(SCROLL_DIV - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_OFF_W-1:0]   c_OFF_LAST   = c_OFF_W'(MSG_LEN - 1);
    localparam logic [c_OFF_W-1:0]   c_OFF_ONE    = c_OFF_W'(1);
    localparam logic [c_OFF_W:0]     c_MSG_LEN_X  = (c_OFF_W + 1)'(MSG_LEN);
    localparam logic [NUM_COLS-1:0]  c_COL_ONE    = NUM_COLS'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BLANK = 2'd1;
    localparam logic [1:0] c_ST_DRIVE = 2'd2;

    logic                 r_run;
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_IDX_W-1:0]   r_col_idx;
    logic [c_CNT_W-1:0]   r_scan_cnt;
    logic                 r_pending;
    logic [c_OFF_W-1:0]   r_msg_offset;
    logic                 r_scroll_tick;

    logic [1:0]           w_state;
    logic                 w_active;
    logic                 w_req;
    logic                 w_apply;
    logic [c_OFF_W-1:0]   w_load_val;
    logic [c_OFF_W-1:0]   w_step_val;

    // State is decoded from the run flag and the prescaler phase.
    always_comb begin
        w_state = c_ST_IDLE;
        if (r_run) begin
            w_state = (r_presc < c_BLANK_END) ? c_ST_BLANK : c_ST_DRIVE;
        end
        col_n = '1;
        if (w_state == c_ST_DRIVE) begin
            col_n = ~(c_COL_ONE << r_col_idx);
        end
    end

    assign scan_tick   = r_run && (r_presc == c_PRESC_LAST);
    assign frame_done  = scan_tick && (r_col_idx == c_IDX_LAST);
    assign col_idx     = r_col_idx;
    assign msg_offset  = r_msg_offset;
    assign scroll_tick = r_scroll_tick;

    // Counters only advance when running and staying enabled, so dropping en
    // lands in IDLE with column 0 after a single edge.
    assign w_active   = r_run && en;
    assign w_req      = scan_tick && (r_scan_cnt == c_CNT_LAST) && !hold;
    assign w_apply    = frame_done && en && !hold && (r_pending || w_req);
    assign w_load_val = ({1'b0, offset_in} >= c_MSG_LEN_X) ? '0 : offset_in;

    always_comb begin
        w_step_val = r_msg_offset;
        if (dir) begin
            w_step_val = (r_msg_offset == '0) ? c_OFF_LAST : (r_msg_offset - c_OFF_ONE);
        end else begin
            w_step_val = (r_msg_offset == c_OFF_LAST) ? '0 : (r_msg_offset + c_OFF_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run         <= 1'b0;
            r_presc       <= '0;
            r_col_idx     <= '0;
            r_scan_cnt    <= '0;
            r_pending     <= 1'b0;
            r_msg_offset  <= '0;
            r_scroll_tick <= 1'b0;
        end else begin
            r_run <= en;

            if (w_active) begin
                if (scan_tick) begin
                    r_presc    <= '0;
                    r_col_idx  <= (r_col_idx == c_IDX_LAST) ? '0 : (r_col_idx + c_IDX_ONE);
                    r_scan_cnt <= (r_scan_cnt == c_CNT_LAST) ? '0 : (r_scan_cnt + c_CNT_ONE);
                end else begin
                    r_presc <= r_presc + c_PRESC_ONE;
                end
                if (load || hold || w_apply) begin
                    r_pending <= 1'b0;
                end else if (w_req) begin
                    r_pending <= 1'b1;
                end
            end else begin
                r_presc    <= '0;
                r_col_idx  <= '0;
                r_scan_cnt <= '0;
                r_pending  <= 1'b0;
            end

            // A load overrides and swallows any scroll step on the same edge.
            if (load) begin
                r_msg_offset <= w_load_val;
            end else if (w_apply) begin
                r_msg_offset <= w_step_val;
            end
            r_scroll_tick <= w_apply && !load;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_painel_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_painel_scan_scheduler
// Description : Self-checking bench for painel_scan_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_painel_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst, en, hold, dir, load;
    logic [2:0] offset_in;
    logic [3:0] col_n;
    logic [1:0] col_idx;
    logic [2:0] msg_offset;
    logic       scan_tick, frame_done, scroll_tick;

    always #5 clk = ~clk;

    painel_scan_scheduler #(
        .SCAN_DIV   (8),
        .BLANK_CYC  (2),
        .NUM_COLS   (4),
        .SCROLL_DIV (3),
        .MSG_LEN    (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hold        (hold),
        .dir         (dir),
        .load        (load),
        .offset_in   (offset_in),
        .col_n       (col_n),
        .col_idx     (col_idx),
        .msg_offset  (msg_offset),
        .scan_tick   (scan_tick),
        .frame_done  (frame_done),
        .scroll_tick (scroll_tick)
    );

    typedef struct packed {
        logic [3:0] col_n;
        logic [1:0] idx;
        logic [2:0] off;
        logic       st;
        logic       fd;
        logic       stk;
    } obs_t;

    typedef struct {
        int   k;
        obs_t o;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    obs_t sb_q[$];

    // Reference model state (values currently held by the DUT registers)
    int m_run = 0, m_presc = 0, m_col = 0, m_cnt = 0, m_pend = 0, m_off = 0, m_stk = 0;

    function automatic obs_t actual();
        obs_t a;
        a.col_n = col_n;
        a.idx   = col_idx;
        a.off   = msg_offset;
        a.st    = scan_tick;
        a.fd    = frame_done;
        a.stk   = scroll_tick;
        return a;
    endfunction

    function automatic vec_t mk(int k, logic [3:0] c, logic [1:0] i, logic [2:0] o,
                                logic st, logic fd, logic stk);
        vec_t v;
        v.k       = k;
        v.o.col_n = c;
        v.o.idx   = i;
        v.o.off   = o;
        v.o.st    = st;
        v.o.fd    = fd;
        v.o.stk   = stk;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance one clock: predict, push to scoreboard, clock, pop and compare.
    task automatic step();
        obs_t e, a;
        logic [3:0] one;
        int st, fd, req, app;
        int n_run, n_presc, n_col, n_cnt, n_pend, n_off, n_stk;
        one = 4'b0001;
        st  = (m_run != 0 && m_presc == 7) ? 1 : 0;
        fd  = (st != 0 && m_col == 3) ? 1 : 0;
        req = (st != 0 && m_cnt == 2 && !hold) ? 1 : 0;
        app = (fd != 0 && en && !hold && (m_pend != 0 || req != 0)) ? 1 : 0;
        if (rst) begin
            n_run = 0; n_presc = 0; n_col = 0; n_cnt = 0; n_pend = 0; n_off = 0; n_stk = 0;
        end else begin
            n_run = en ? 1 : 0;
            n_off = m_off;
            if (load)
                n_off = (offset_in >= 3'd6) ? 0 : int'(offset_in);
            else if (app != 0)
                n_off = dir ? (m_off + 5) % 6 : (m_off + 1) % 6;
            n_stk = (app != 0 && !load) ? 1 : 0;
            if (m_run != 0 && en) begin
                n_presc = (st != 0) ? 0 : m_presc + 1;
                n_col   = (st != 0) ? (m_col + 1) % 4 : m_col;
                n_cnt   = (st != 0) ? (m_cnt + 1) % 3 : m_cnt;
                n_pend  = (load || hold || app != 0) ? 0 : ((req != 0) ? 1 : m_pend);
            end else begin
                n_presc = 0; n_col = 0; n_cnt = 0; n_pend = 0;
            end
        end
        m_run = n_run; m_presc = n_presc; m_col = n_col; m_cnt = n_cnt;
        m_pend = n_pend; m_off = n_off; m_stk = n_stk;
        e.col_n = (m_run != 0 && m_presc >= 2) ? ~(one << m_col) : 4'hF;
        e.idx   = 2'(m_col);
        e.off   = 3'(m_off);
        e.st    = (m_run != 0 && m_presc == 7);
        e.fd    = (m_run != 0 && m_presc == 7 && m_col == 3);
        e.stk   = (m_stk != 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL model cycle %0d: got col_n=%b idx=%0d off=%0d st=%b fd=%b stk=%b expected col_n=%b idx=%0d off=%0d st=%b fd=%b stk=%b",
                     cyc, a.col_n, a.idx, a.off, a.st, a.fd, a.stk,
                     e.col_n, e.idx, e.off, e.st, e.fd, e.stk);
        end
        @(negedge clk);
    endtask

    task automatic wait_scroll(string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (scroll_tick) seen = 1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s: no scroll_tick within 200 cycles, got 0 expected 1", name);
        end
    endtask

    vec_t tab[15];

    initial begin
        int ti;
        int seen_stk;
        bit found;

        tab[0]  = mk(1,  4'hF, 0, 0, 0, 0, 0);
        tab[1]  = mk(2,  4'hF, 0, 0, 0, 0, 0);
        tab[2]  = mk(3,  4'hE, 0, 0, 0, 0, 0);
        tab[3]  = mk(8,  4'hE, 0, 0, 1, 0, 0);
        tab[4]  = mk(9,  4'hF, 1, 0, 0, 0, 0);
        tab[5]  = mk(11, 4'hD, 1, 0, 0, 0, 0);
        tab[6]  = mk(27, 4'h7, 3, 0, 0, 0, 0);
        tab[7]  = mk(32, 4'h7, 3, 0, 1, 1, 0);
        tab[8]  = mk(33, 4'hF, 0, 1, 0, 0, 1);
        tab[9]  = mk(34, 4'hF, 0, 1, 0, 0, 0);
        tab[10] = mk(40, 4'hE, 0, 1, 1, 0, 0);
        tab[11] = mk(64, 4'h7, 3, 1, 1, 1, 0);
        tab[12] = mk(65, 4'hF, 0, 2, 0, 0, 1);
        tab[13] = mk(96, 4'h7, 3, 2, 1, 1, 0);
        tab[14] = mk(97, 4'hF, 0, 3, 0, 0, 1);

        rst = 1'b1; en = 1'b0; hold = 1'b0; dir = 1'b0; load = 1'b0; offset_in = 3'd0;
        @(negedge clk);
        step();
        chk("reset_col_n", int'(col_n), 15);
        chk("reset_idx", int'(col_idx), 0);
        chk("reset_off", int'(msg_offset), 0);
        chk("reset_scan_tick", int'(scan_tick), 0);
        chk("reset_scroll_tick", int'(scroll_tick), 0);

        // Scan sequence and deferred scrolling against hand-derived vectors
        rst = 1'b0; en = 1'b1;
        ti = 0;
        for (int k = 1; k <= 97; k++) begin
            step();
            if (ti < 15 && tab[ti].k == k) begin
                obs_t a;
                a = actual();
                checks++;
                if (a !== tab[ti].o) begin
                    errors++;
                    $display("FAIL vector k=%0d: got %b expected %b", k, a, tab[ti].o);
                end
                ti++;
            end
        end

        // Wrap-around in both directions
        load = 1'b1; offset_in = 3'd5;
        step();
        load = 1'b0;
        chk("load5", int'(msg_offset), 5);
        wait_scroll("wrap_up");
        chk("wrap_up_off", int'(msg_offset), 0);
        dir = 1'b1; load = 1'b1; offset_in = 3'd0;
        step();
        load = 1'b0;
        chk("load0", int'(msg_offset), 0);
        wait_scroll("wrap_down");
        chk("wrap_down_off", int'(msg_offset), 5);

        // Hold freezes scrolling across several frames
        hold = 1'b1;
        seen_stk = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (scroll_tick) seen_stk++;
        end
        chk("hold_scroll_ticks", seen_stk, 0);
        chk("hold_off", int'(msg_offset), 5);
        hold = 1'b0;
        wait_scroll("hold_release");
        chk("hold_release_off", int'(msg_offset), 4);

        // Mid-slot stop while driving column 2, then restart
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (col_idx == 2'd2 && col_n != 4'hF) found = 1;
            else step();
        end
        chk("stop_found_drive_col2", int'(found), 1);
        en = 1'b0;
        step();
        chk("stop_col_n", int'(col_n), 15);
        chk("stop_idx", int'(col_idx), 0);
        chk("stop_off", int'(msg_offset), 4);
        for (int i = 0; i < 3; i++) step();
        chk("idle_col_n", int'(col_n), 15);
        en = 1'b1;
        step();
        chk("restart_blank0", int'(col_n), 15);
        step();
        chk("restart_blank1", int'(col_n), 15);
        step();
        chk("restart_drive0", int'(col_n), 14);

        // Load with out-of-range value on a frame_done edge with pending set
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_run != 0 && m_presc == 7 && m_col == 3 && m_pend != 0) found = 1;
            else step();
        end
        chk("conflict_found", int'(found), 1);
        load = 1'b1; offset_in = 3'd7;
        step();
        load = 1'b0; offset_in = 3'd0;
        chk("conflict_off", int'(msg_offset), 0);
        chk("conflict_scroll_tick", int'(scroll_tick), 0);
        step();
        chk("conflict_scroll_tick_next", int'(scroll_tick), 0);

        // Reset mid-frame
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        chk("midrst_col_n", int'(col_n), 15);
        chk("midrst_idx", int'(col_idx), 0);
        chk("midrst_off", int'(msg_offset), 0);
        chk("midrst_scan_tick", int'(scan_tick), 0);
        rst = 1'b0; en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
